// File: rtl/rf_pkg.sv
// Shared types and sizing for the register-file writeback arbiter slice.
package rf_pkg;

   localparam int XLEN         = 32;
   localparam int AW           = 5;
   localparam int NREG         = 1 << AW;
   localparam int LQ_DEPTH     = 4;
   localparam int STARVE_LIMIT = 3;

   // One register-file write: destination plus data.
   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] wd;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding buffered L-unit writeback results.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = LQ_DEPTH
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t din,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output wb_req_t head
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   wb_req_t       mem [DEPTH];

   // Full when the wrap bits differ and the index bits match.
   assign full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
   assign empty = (wptr == rptr);
   assign head  = mem[rptr[IW-1:0]];

   // Pointer update; pushes into a full FIFO and pops from an empty one are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + PW'(1);
         if (pop && !empty) rptr <= rptr + PW'(1);
      end
   end

   // Storage write; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr[IW-1:0]] <= din;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the in-order pipeline
// writeback (P) and a variable-latency unit (L) whose results are queued.
// P has priority unless the queued L head has lost STARVE_LIMIT times in a row.
// A pending bitmap tracks in-flight L destinations for decode hazard stalls.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the posedge; ready never depends on the same channel's valid.
//   p_ready   = !force_l
//   l_ready   = !full
//   iss_ready = !pending[iss_rd]
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int LQ_DEPTH_P     = LQ_DEPTH,
   parameter int STARVE_LIMIT_P = STARVE_LIMIT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p_valid,
   input  logic [AW-1:0]   p_rd,
   input  logic [XLEN-1:0] p_wd,
   output logic            p_ready,
   input  logic            l_valid,
   input  logic [AW-1:0]   l_rd,
   input  logic [XLEN-1:0] l_wd,
   output logic            l_ready,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_ready,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            stall,
   output logic            we3,
   output logic [AW-1:0]   rd,
   output logic [XLEN-1:0] wd3
);

   localparam int STW = $clog2(STARVE_LIMIT_P + 1);

   logic            full;
   logic            empty;
   wb_req_t         head;
   wb_req_t         l_req;
   logic            push;
   logic            pop;
   logic            force_l;
   logic            grant_l;
   logic            grant_p;
   logic            iss_fire;
   logic [STW-1:0]  starve_cnt;
   logic [STW-1:0]  starve_nxt;
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;

   assign l_req = '{rd: l_rd, wd: l_wd};

   rf_wb_fifo #(
      .DEPTH (LQ_DEPTH_P)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (l_req),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // Arbitration and handshake readies: forced L head, then P, then any L head.
   always_comb begin
      force_l   = (starve_cnt == STW'(STARVE_LIMIT_P)) && !empty;
      grant_l   = force_l || (!p_valid && !empty);
      grant_p   = !force_l && p_valid;
      p_ready   = !force_l;
      l_ready   = !full;
      push      = l_valid && !full;
      pop       = grant_l;
      iss_ready = !pending[iss_rd];
      iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
      stall     = pending[rs1] | pending[rs2];
   end

   // Next pending bitmap: the popped head clears its bit, a new issue sets one; set wins.
   always_comb begin
      pending_nxt = pending;
      if (pop)      pending_nxt[head.rd] = 1'b0;
      if (iss_fire) pending_nxt[iss_rd]  = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Next starvation count: counts consecutive P wins over a waiting L head.
   always_comb begin
      starve_nxt = starve_cnt;
      if (empty || grant_l) begin
         starve_nxt = '0;
      end else if (grant_p && (starve_cnt != STW'(STARVE_LIMIT_P))) begin
         starve_nxt = starve_cnt + STW'(1);
      end
   end

   // Bookkeeping registers: pending bitmap and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         starve_cnt <= '0;
      end else begin
         pending    <= pending_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Write-port register: one cycle after the grant; x0 grants keep we3 low.
   always_ff @(posedge clk) begin
      if (rst) begin
         we3 <= 1'b0;
         rd  <= '0;
         wd3 <= '0;
      end else if (grant_l) begin
         we3 <= (head.rd != '0);
         rd  <= head.rd;
         wd3 <= head.wd;
      end else if (grant_p) begin
         we3 <= (p_rd != '0);
         rd  <= p_rd;
         wd3 <= p_wd;
      end else begin
         we3 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst;
   logic            p_valid;
   logic [AW-1:0]   p_rd;
   logic [XLEN-1:0] p_wd;
   logic            p_ready;
   logic            l_valid;
   logic [AW-1:0]   l_rd;
   logic [XLEN-1:0] l_wd;
   logic            l_ready;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic            iss_ready;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic            stall;
   logic            we3;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] wd3;

   int tests;
   int fails;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .p_valid   (p_valid),
      .p_rd      (p_rd),
      .p_wd      (p_wd),
      .p_ready   (p_ready),
      .l_valid   (l_valid),
      .l_rd      (l_rd),
      .l_wd      (l_wd),
      .l_ready   (l_ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .stall     (stall),
      .we3       (we3),
      .rd        (rd),
      .wd3       (wd3)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one cycle and sample 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      p_valid   = 1'b0;
      p_rd      = '0;
      p_wd      = '0;
      l_valid   = 1'b0;
      l_rd      = '0;
      l_wd      = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      rs1       = '0;
      rs2       = '0;

      // ---- reset state
      tick();
      tick();
      chk("rst_we3", 64'(we3), 64'd0);
      chk("rst_rd", 64'(rd), 64'd0);
      chk("rst_wd3", 64'(wd3), 64'd0);
      chk("rst_l_ready", 64'(l_ready), 64'd1);
      chk("rst_p_ready", 64'(p_ready), 64'd1);
      chk("rst_iss_ready", 64'(iss_ready), 64'd1);
      chk("rst_stall", 64'(stall), 64'd0);
      rst = 1'b0;

      // ---- 1: single P write
      p_valid = 1'b1; p_rd = 5'd5; p_wd = 32'hDEADBEEF;
      #1;
      chk("t1_p_ready", 64'(p_ready), 64'd1);
      tick();
      p_valid = 1'b0;
      #1;
      chk("t1_we3", 64'(we3), 64'd1);
      chk("t1_rd", 64'(rd), 64'd5);
      chk("t1_wd3", 64'(wd3), 64'hDEADBEEF);
      chk("t1_p_ready2", 64'(p_ready), 64'd1);
      tick();
      chk("t1_idle_we3", 64'(we3), 64'd0);
      chk("t1_idle_rd_hold", 64'(rd), 64'd5);
      chk("t1_idle_wd3_hold", 64'(wd3), 64'hDEADBEEF);

      // ---- 2: issue rd=7, then L result for it
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      chk("t2_iss_ready", 64'(iss_ready), 64'd1);
      tick();
      iss_valid = 1'b0; rs1 = 5'd7;
      #1;
      chk("t2_stall_issued", 64'(stall), 64'd1);
      chk("t2_iss_ready_blocked", 64'(iss_ready), 64'd0);
      l_valid = 1'b1; l_rd = 5'd7; l_wd = 32'h1234;
      #1;
      chk("t2_l_ready", 64'(l_ready), 64'd1);
      tick();
      l_valid = 1'b0;
      #1;
      chk("t2_no_bypass_we3", 64'(we3), 64'd0);
      chk("t2_stall_queued", 64'(stall), 64'd1);
      tick();
      chk("t2_we3", 64'(we3), 64'd1);
      chk("t2_rd", 64'(rd), 64'd7);
      chk("t2_wd3", 64'(wd3), 64'h1234);
      chk("t2_stall_cleared", 64'(stall), 64'd0);
      chk("t2_iss_ready_again", 64'(iss_ready), 64'd1);
      rs1 = '0;

      // ---- 3: starvation guard with P saturating
      p_valid = 1'b1; p_rd = 5'd10; p_wd = 32'hA0;
      l_valid = 1'b1; l_rd = 5'd9; l_wd = 32'h99;
      #1;
      chk("t3_p_ready0", 64'(p_ready), 64'd1);
      tick();
      l_valid = 1'b0; p_rd = 5'd11; p_wd = 32'hA1;
      #1;
      chk("t3_rd10", 64'(rd), 64'd10);
      chk("t3_p_ready1", 64'(p_ready), 64'd1);
      tick();
      p_rd = 5'd12; p_wd = 32'hA2;
      #1;
      chk("t3_rd11", 64'(rd), 64'd11);
      chk("t3_p_ready2", 64'(p_ready), 64'd1);
      tick();
      p_rd = 5'd13; p_wd = 32'hA3;
      #1;
      chk("t3_rd12", 64'(rd), 64'd12);
      chk("t3_p_ready3", 64'(p_ready), 64'd1);
      tick();
      chk("t3_rd13", 64'(rd), 64'd13);
      chk("t3_forced_p_ready", 64'(p_ready), 64'd0);
      tick();
      chk("t3_l_we3", 64'(we3), 64'd1);
      chk("t3_l_rd", 64'(rd), 64'd9);
      chk("t3_l_wd3", 64'(wd3), 64'h99);
      chk("t3_p_ready_back", 64'(p_ready), 64'd1);
      tick();
      chk("t3_p_after_rd", 64'(rd), 64'd13);

      // ---- 4: fill the FIFO while P saturates, then drain
      p_rd = 5'd20; p_wd = 32'hB0;
      for (int i = 0; i < 4; i++) begin
         l_valid = 1'b1; l_rd = 5'(21 + i); l_wd = 32'(32'h100 + i);
         #1;
         chk($sformatf("t4_l_ready_%0d", i), 64'(l_ready), 64'd1);
         chk($sformatf("t4_p_ready_%0d", i), 64'(p_ready), 64'd1);
         tick();
      end
      l_rd = 5'd25; l_wd = 32'h1FF;
      #1;
      chk("t4_full_l_ready", 64'(l_ready), 64'd0);
      chk("t4_full_p_ready", 64'(p_ready), 64'd0);
      tick();
      l_valid = 1'b0; p_valid = 1'b0;
      #1;
      chk("t4_drain0_we3", 64'(we3), 64'd1);
      chk("t4_drain0_rd", 64'(rd), 64'd21);
      chk("t4_drain0_wd3", 64'(wd3), 64'h100);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk($sformatf("t4_drain%0d_rd", i), 64'(rd), 64'(21 + i));
         chk($sformatf("t4_drain%0d_wd3", i), 64'(wd3), 64'(32'h100 + i));
         chk($sformatf("t4_drain%0d_we3", i), 64'(we3), 64'd1);
      end
      tick();
      chk("t4_drained_we3", 64'(we3), 64'd0);
      chk("t4_drained_rd_hold", 64'(rd), 64'd24);

      // ---- 5: x0 requests
      p_valid = 1'b1; p_rd = 5'd0; p_wd = 32'hFFFFFFFF;
      #1;
      chk("t5_p_ready", 64'(p_ready), 64'd1);
      tick();
      p_valid = 1'b0;
      #1;
      chk("t5_we3_x0", 64'(we3), 64'd0);
      iss_valid = 1'b1; iss_rd = 5'd0;
      #1;
      chk("t5_iss_ready_x0", 64'(iss_ready), 64'd1);
      tick();
      iss_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
      #1;
      chk("t5_stall_x0", 64'(stall), 64'd0);
      chk("t5_iss_ready_x0_after", 64'(iss_ready), 64'd1);

      // ---- 6: reset with queued results and pending {3,4,6}
      iss_valid = 1'b1; iss_rd = 5'd3; tick();
      iss_rd = 5'd4; tick();
      iss_rd = 5'd6; tick();
      iss_valid = 1'b0;
      p_valid = 1'b1; p_rd = 5'd1; p_wd = 32'h11;
      l_valid = 1'b1; l_rd = 5'd3; l_wd = 32'h33; tick();
      l_rd = 5'd4; l_wd = 32'h44; tick();
      l_rd = 5'd6; l_wd = 32'h66; tick();
      l_valid = 1'b0; rs1 = 5'd3; rs2 = 5'd0;
      #1;
      chk("t6_pre_stall", 64'(stall), 64'd1);
      chk("t6_pre_p_ready", 64'(p_ready), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; p_valid = 1'b0;
      #1;
      chk("t6_we3", 64'(we3), 64'd0);
      chk("t6_rd", 64'(rd), 64'd0);
      chk("t6_wd3", 64'(wd3), 64'd0);
      chk("t6_l_ready", 64'(l_ready), 64'd1);
      rs1 = 5'd3; rs2 = 5'd4;
      #1;
      chk("t6_stall_3_4", 64'(stall), 64'd0);
      rs1 = 5'd6; rs2 = 5'd6;
      #1;
      chk("t6_stall_6", 64'(stall), 64'd0);
      tick();
      chk("t6_empty_we3_a", 64'(we3), 64'd0);
      tick();
      chk("t6_empty_we3_b", 64'(we3), 64'd0);

      // ---- 7: issue and pop of the same register in one cycle; set wins
      rs1 = 5'd7; rs2 = 5'd0;
      l_valid = 1'b1; l_rd = 5'd7; l_wd = 32'h77;
      tick();
      l_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      chk("t7_iss_ready", 64'(iss_ready), 64'd1);
      chk("t7_stall_before", 64'(stall), 64'd0);
      tick();
      iss_valid = 1'b0;
      #1;
      chk("t7_we3", 64'(we3), 64'd1);
      chk("t7_rd", 64'(rd), 64'd7);
      chk("t7_pending_set_wins", 64'(stall), 64'd1);
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      chk("t7_iss_ready_busy", 64'(iss_ready), 64'd0);
      tick();
      iss_valid = 1'b0;
      l_valid = 1'b1; l_rd = 5'd7; l_wd = 32'h78;
      tick();
      l_valid = 1'b0;
      tick();
      chk("t7_final_rd", 64'(rd), 64'd7);
      chk("t7_final_wd3", 64'(wd3), 64'h78);
      chk("t7_final_stall", 64'(stall), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
